// File: rtl/spi_slave_word_if.sv
// Pin and decoder-side bundle of the SPI mode 0 word slave.
// Parity builds (SPI_SLAVE_WORD_PARITY_EN) add the sticky parity_err flag.
interface spi_slave_word_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
);
    // Single strobes, no backpressure: rx_valid marks one sclk cycle in which
    // rx_data is new; tx_load marks the negedge at which tx_data was taken.
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [WORD_W-1:0] tx_data;
    logic              tx_load;
    logic [CNT_W-1:0]  word_cnt;
    logic              short_frame;
    logic              rx_busy;
`ifdef SPI_SLAVE_WORD_PARITY_EN
    logic              parity_err;

    modport slave (
        input  cs_n, mosi, tx_data,
        output miso, rx_data, rx_valid, tx_load, word_cnt, short_frame, rx_busy, parity_err
    );
    modport master (
        output cs_n, mosi, tx_data,
        input  miso, rx_data, rx_valid, tx_load, word_cnt, short_frame, rx_busy, parity_err
    );
`else
    modport slave (
        input  cs_n, mosi, tx_data,
        output miso, rx_data, rx_valid, tx_load, word_cnt, short_frame, rx_busy
    );
    modport master (
        output cs_n, mosi, tx_data,
        input  miso, rx_data, rx_valid, tx_load, word_cnt, short_frame, rx_busy
    );
`endif
endinterface

// File: rtl/spi_slave_word.sv
// SPI mode 0 slave moving WORD_W-bit words between the pins and the register decoder.
// Optional trailing even-parity bit per word with SPI_SLAVE_WORD_PARITY_EN.
module spi_slave_word #(
    parameter int WORD_W    = 8,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 8
) (
    input logic             sclk,
    input logic             rst_n,
    spi_slave_word_if.slave bus
);
`ifdef SPI_SLAVE_WORD_PARITY_EN
    localparam int LAST_BIT = WORD_W;
`else
    localparam int LAST_BIT = WORD_W - 1;
`endif
    localparam int BCW = $clog2(WORD_W + 1);
    localparam logic [BCW-1:0] DATA_END  = BCW'(WORD_W - 1);
    localparam logic [BCW-1:0] FRAME_END = BCW'(LAST_BIT);

    typedef enum logic {IDLE, SHIFT} rx_state_t;

    rx_state_t         state_q, state_d;
    logic [WORD_W-1:0] rx_sh_q, rx_sh_d, rx_shifted;
    logic [BCW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              short_q, short_d;
`ifdef SPI_SLAVE_WORD_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            word_cnt_q <= '0;
            short_q    <= 1'b0;
`ifdef SPI_SLAVE_WORD_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            word_cnt_q <= word_cnt_d;
            short_q    <= short_d;
`ifdef SPI_SLAVE_WORD_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        word_cnt_d = word_cnt_q;
        short_d    = short_q;
`ifdef SPI_SLAVE_WORD_PARITY_EN
        par_err_d  = par_err_q;
`endif
        if (LSB_FIRST != 0) rx_shifted = {bus.mosi, rx_sh_q[WORD_W-1:1]};
        else                rx_shifted = {rx_sh_q[WORD_W-2:0], bus.mosi};

        if (bus.cs_n) begin
            // A partial word at deselect is dropped; rx_data keeps the last good word.
            state_d  = IDLE;
            rx_cnt_d = '0;
            if (rx_cnt_q != '0) short_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SHIFT;
                    rx_sh_d    = rx_shifted;
                    rx_cnt_d   = BCW'(1);
                    word_cnt_d = '0;
                end
                default: begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
`ifdef SPI_SLAVE_WORD_PARITY_EN
                    if (rx_cnt_q == FRAME_END) begin
                        rx_cnt_d = '0;
                        if ((^rx_data_q) != bus.mosi) par_err_d = 1'b1;
                    end else begin
                        rx_sh_d = rx_shifted;
                    end
`else
                    rx_sh_d = rx_shifted;
                    if (rx_cnt_q == FRAME_END) rx_cnt_d = '0;
`endif
                    if (rx_cnt_q == DATA_END) begin
                        rx_data_d  = rx_shifted;
                        rx_valid_d = 1'b1;
                        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // TX runs on the falling edge so each bit is stable across the master's sampling edge.
    logic [WORD_W-1:0] tx_sh_q, tx_shifted;
    logic [BCW-1:0]    tx_cnt_q;
    logic              tx_load_q;
    logic              tx_bit;
`ifdef SPI_SLAVE_WORD_PARITY_EN
    logic              tx_par_q;
`endif

    always_comb begin
        if (LSB_FIRST != 0) begin
            tx_shifted = {1'b0, tx_sh_q[WORD_W-1:1]};
            tx_bit     = tx_sh_q[0];
        end else begin
            tx_shifted = {tx_sh_q[WORD_W-2:0], 1'b0};
            tx_bit     = tx_sh_q[WORD_W-1];
        end
`ifdef SPI_SLAVE_WORD_PARITY_EN
        if (tx_cnt_q == FRAME_END) tx_bit = tx_par_q;
`endif
    end

    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh_q   <= '0;
            tx_cnt_q  <= '0;
            tx_load_q <= 1'b0;
`ifdef SPI_SLAVE_WORD_PARITY_EN
            tx_par_q  <= 1'b0;
`endif
        end else if (bus.cs_n || tx_cnt_q == FRAME_END) begin
            tx_sh_q   <= bus.tx_data;
            tx_cnt_q  <= '0;
            tx_load_q <= 1'b1;
`ifdef SPI_SLAVE_WORD_PARITY_EN
            tx_par_q  <= ^bus.tx_data;
`endif
        end else begin
            tx_sh_q   <= tx_shifted;
            tx_cnt_q  <= tx_cnt_q + 1'b1;
            tx_load_q <= 1'b0;
        end
    end

    assign bus.miso        = bus.cs_n ? 1'b0 : tx_bit;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_load     = tx_load_q;
    assign bus.word_cnt    = word_cnt_q;
    assign bus.short_frame = short_q;
    assign bus.rx_busy     = (state_q == SHIFT);
`ifdef SPI_SLAVE_WORD_PARITY_EN
    assign bus.parity_err  = par_err_q;
`endif
endmodule
